// File: rtl/tpu_load_buffer.sv
// Operand store in front of the systolic MMU. It captures 4 weight bytes and
// then 4 input bytes from a serial stream, and serves registered reads to the MMU.
module tpu_load_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              load_done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_load_done;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_data;

  logic w_full;
  logic w_wr_accept;

  // load_en is a one-cycle strobe with no back-pressure. A strobe that
  // arrives while full or together with clear is dropped.
  assign w_full      = (r_count == C_DEPTH);
  assign w_wr_accept = load_en && !clear && !w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_load_done <= w_wr_accept && (r_count == C_LAST);
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
      if (load_en && w_full) r_overflow <= 1'b1;
    end
  end

  // No write-to-read bypass: a same-address collision returns the old byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data <= '0;
    else      r_rd_data <= r_mem[mem_addr];
  end

  assign rd_data   = r_rd_data;
  assign count     = r_count;
  assign full      = w_full;
  assign load_done = r_load_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tpu_load_buffer.sv
// Randomized and directed bench for tpu_load_buffer, checked against a
// behavioural model through an expected-response queue.
module tb_tpu_load_buffer;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [7:0] data_in;
  logic       clear;
  logic [2:0] mem_addr;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       load_done;
  logic       overflow;

  tpu_load_buffer #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .data_in   (data_in),
    .clear     (clear),
    .mem_addr  (mem_addr),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .load_done (load_done),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {rd_data, count, full, load_done, overflow}
  logic [14:0] exp_q[$];

  // reference model: plain array plus fill level
  logic [7:0] m_mem [8];
  int         m_cnt;
  logic       m_done;
  logic       m_ov;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_cnt  = 0;
    m_done = 1'b0;
    m_ov   = 1'b0;
  endtask

  // driver: one call = one clock cycle of stimulus plus its expected response
  task automatic step(input logic le, input logic [7:0] d, input logic cl,
                      input logic [2:0] a);
    logic [7:0] e_rd;
    @(negedge clk);
    load_en  = le;
    data_in  = d;
    clear    = cl;
    mem_addr = a;
    e_rd = m_mem[a];
    if (cl) begin
      m_cnt  = 0;
      m_ov   = 1'b0;
      m_done = 1'b0;
    end else if (le && m_cnt == 8) begin
      m_ov   = 1'b1;
      m_done = 1'b0;
    end else if (le) begin
      m_mem[m_cnt] = d;
      m_cnt++;
      m_done = (m_cnt == 8);
    end else begin
      m_done = 1'b0;
    end
    exp_q.push_back({e_rd, 4'(m_cnt), (m_cnt == 8), m_done, m_ov});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},   rd_data,   0);
    check({tag, "_cnt"},  count,     0);
    check({tag, "_full"}, full,      0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_ov"},   overflow,  0);
  endtask

  // async reset dropped between clock edges, released on a falling edge
  task automatic mid_cycle_reset();
    @(posedge clk);
    #3;
    load_en = 1'b0;
    clear   = 1'b0;
    rst     = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [14:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data",   rd_data,   e[14:7]);
      check("count",     count,     e[6:3]);
      check("full",      full,      e[2]);
      check("load_done", load_done, e[1]);
      check("overflow",  overflow,  e[0]);
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst      = 1'b1;
    load_en  = 1'b0;
    data_in  = 8'h00;
    clear    = 1'b0;
    mem_addr = 3'd0;
    model_reset();
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // full load 0x11..0x88, then one idle cycle for the load_done drop
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0);

    // two read walks
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 3'(i));
    step(1'b0, 8'h00, 1'b0, 3'd0);

    // write while full, then clear, then read addr 0
    step(1'b1, 8'hFF, 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b1, 3'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0);

    // clear beats load_en, next load goes to entry 0
    step(1'b1, 8'hAA, 1'b1, 3'd0);
    step(1'b1, 8'h5A, 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0);

    // gapped partial load, then async reset mid-cycle
    step(1'b0, 8'h00, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 3'd0);
      step(1'b0, 8'h00, 1'b0, 3'd0);
    end
    mid_cycle_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 3'(i));
    step(1'b0, 8'h00, 1'b0, 3'd0);

    // read/write collision on addr 2
    step(1'b1, 8'h11, 1'b0, 3'd0);
    step(1'b1, 8'h22, 1'b0, 3'd0);
    step(1'b1, 8'h33, 1'b0, 3'd2);
    step(1'b0, 8'h00, 1'b0, 3'd2);
    step(1'b0, 8'h00, 1'b0, 3'd2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) mid_cycle_reset();
      step(($urandom_range(0, 99) < 60), 8'($urandom),
           ($urandom_range(0, 99) < 6), 3'($urandom_range(0, 7)));
    end
    step(1'b0, 8'h00, 1'b0, 3'd0);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tpu_load_buffer.md
Name: tpu_load_buffer

Overview:
- Operand store that sits directly upstream of the systolic MMU and is addressed by the control unit.
- During the load phase it captures a serial byte stream: 4 weight bytes, then 4 input bytes, into an 8-entry register file.
- During compute it returns the entry selected by the control unit's mem_addr, one cycle later, to feed the MMU.
- It flags load completion and overflow so the control unit can sequence LOAD -> COMPUTE.

Parameters:
- DATA_W, 8, width of each stored operand byte.
- DEPTH, 8, number of entries. Entries 0-3 hold weights W00,W01,W10,W11; entries 4-7 hold inputs X00,X01,X10,X11.
- ADDR_W, 3, address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_en  input  1  write strobe; data_in is valid this cycle.
- data_in  input  DATA_W  operand byte to store.
- clear  input  1  synchronous restart of the load sequence (pointer and flags only).
- mem_addr  input  ADDR_W  read address from the control unit.
- rd_data  output  DATA_W  registered read data, mem[mem_addr] from the previous cycle.
- count  output  ADDR_W+1  number of entries written since reset or clear (0..8).
- full  output  1  high when count == DEPTH.
- load_done  output  1  one-cycle pulse on the cycle count becomes DEPTH.
- overflow  output  1  sticky; set when load_en arrives while full.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr=0, count=0, full=0, load_done=0, overflow=0, rd_data=0.
  - All memory entries cleared to 0.
  - Release is synchronous to clk.
- Write:
  - When load_en=1, clear=0 and full=0: mem[wr_ptr] <= data_in; wr_ptr increments; count increments.
  - wr_ptr wraps 7 -> 0, but no further writes occur until clear, because full blocks them.
- Full and load_done:
  - full = (count == DEPTH), decoded from count, so it is high the cycle after the 8th write.
  - load_done is registered: high exactly the cycle after the 8th accepted write, low otherwise.
- Write while full:
  - Data discarded; mem, count and wr_ptr unchanged.
  - overflow <= 1 and holds until clear or reset.
- Clear (synchronous):
  - wr_ptr=0, count=0, overflow=0, load_done=0.
  - Memory contents preserved; stale data is overwritten by the next load.
- clear and load_en in the same cycle: clear wins and the write is discarded.
- Read:
  - rd_data <= mem[mem_addr] every cycle, unconditionally. Latency is 1 cycle.
  - Any mem_addr value is legal, because DEPTH equals 2^ADDR_W.
- Read/write collision (same address, same cycle): rd_data returns the old contents; there is no bypass.
- Partial load (count < 8): reads return the current contents, i.e. 0 after reset or prior-load values after clear. No error is flagged; sequencing is the control unit's responsibility.
- Reset mid-load: everything returns to reset values immediately, even between clock edges.
- No arithmetic beyond the pointer and counter increments. The counter saturates at DEPTH.

Test Plan:
- Reset, then 8 consecutive load_en with data 0x11,0x22,...,0x88 -> count steps 1..8; full=1 and load_done=1 on the cycle after the 8th write; load_done=0 the following cycle.
- After the full load, drive mem_addr 0..7 on consecutive cycles -> rd_data shows 0x11..0x88 each one cycle behind its address; a second walk gives identical values.
- With full=1, pulse load_en with 0xFF -> overflow=1, count stays 8, mem[0] still 0x11. Then clear -> overflow=0, count=0, and reading addr 0 still returns 0x11.
- After clear, assert load_en (data 0xAA) and clear in the same cycle -> count stays 0. Next cycle load 0x5A -> mem[0]=0x5A, count=1.
- Load 3 bytes with gaps (load_en low between them), then drop rst low asynchronously mid-cycle -> all outputs 0 immediately; reading addr 0..2 after release returns 0x00.
- Same-cycle write of 0x33 to addr 2 with mem_addr=2 (old value 0x00) -> rd_data=0x00 next cycle, 0x33 the cycle after.
